// File: rtl/wb_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// wb_commit_ctrl_if : MEM->WB, WB->CSR/GPR and WB<->fetch redirect signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_commit_ctrl_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [31:0] ms_vaddr;
  logic [5:0]  ms_ex_vec;
  logic        ms_ertn;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask;
  logic [31:0] ms_csr_wvalue;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_csr_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic [31:0] debug_wb_pc;

  // WB stage side
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_vaddr, ms_ex_vec, ms_ertn,
           ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
           ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           has_int, ex_entry, ertn_entry, redirect_ready,
    output ws_allowin, csr_we, csr_num, csr_wmask, csr_wvalue,
           wb_ex, ertn_flush, wb_csr_pc, wb_vaddr, wb_ecode, wb_esubcode,
           rf_we, rf_waddr, rf_wdata, flush_out,
           redirect_valid, redirect_pc, debug_wb_pc
  );

  // Environment side (MEM, CSR file, fetch)
  modport master (
    output ms_to_ws_valid, ms_pc, ms_vaddr, ms_ex_vec, ms_ertn,
           ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
           ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           has_int, ex_entry, ertn_entry, redirect_ready,
    input  ws_allowin, csr_we, csr_num, csr_wmask, csr_wvalue,
           wb_ex, ertn_flush, wb_csr_pc, wb_vaddr, wb_ecode, wb_esubcode,
           rf_we, rf_waddr, rf_wdata, flush_out,
           redirect_valid, redirect_pc, debug_wb_pc
  );
endinterface

`default_nettype wire

// File: rtl/wb_commit_ctrl.sv
// ---------------------------------------------------------------------------
// wb_commit_ctrl : WB/commit stage, exception prioritisation, flush/redirect.
// Optional perf counters with `define WB_PERF_CNT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_commit_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  wb_commit_ctrl_if.slave       bus
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_commit_cnt,
  output logic [31:0]           perf_ex_cnt
`endif
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_REDIR = 1'b1
  } state_e;

  state_e      state_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic        ws_valid_q;
  logic [31:0] ws_pc_q;
  logic [31:0] ws_vaddr_q;
  logic [5:0]  ws_ex_vec_q;
  logic        ws_ertn_q;
  logic        ws_csr_we_q;
  logic [13:0] ws_csr_num_q;
  logic [31:0] ws_csr_wmask_q;
  logic [31:0] ws_csr_wvalue_q;
  logic        ws_rf_we_q;
  logic [4:0]  ws_rf_waddr_q;
  logic [31:0] ws_rf_wdata_q;

  logic        ws_valid_d;
  logic        in_run;
  logic        ws_ex;
  logic        ertn_now;
  logic        flush_now;
  logic        allowin;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;

  assign in_run    = (state_q == S_RUN);
  // has_int only counts against a live instruction in RUN; otherwise it waits
  assign ws_ex     = ws_valid_q && in_run && (bus.has_int || (|ws_ex_vec_q));
  assign ertn_now  = ws_valid_q && in_run && ws_ertn_q && !ws_ex;
  assign flush_now = in_run && (ws_ex || ertn_now);
  assign allowin   = in_run && !flush_now;
  assign ws_valid_d = bus.ms_to_ws_valid && allowin;

  always_comb begin
    ecode    = 6'h00;
    esubcode = 9'h000;
    if (ws_ex) begin
      if (bus.has_int)         ecode = 6'h00;
      else if (ws_ex_vec_q[0]) ecode = 6'h08;
      else if (ws_ex_vec_q[1]) ecode = 6'h0D;
      else if (ws_ex_vec_q[2]) ecode = 6'h0B;
      else if (ws_ex_vec_q[3]) ecode = 6'h0C;
      else if (ws_ex_vec_q[4]) begin
        ecode    = 6'h08;
        esubcode = 9'h001;
      end else                 ecode = 6'h09;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q      <= 1'b0;
      ws_pc_q         <= 32'h0;
      ws_vaddr_q      <= 32'h0;
      ws_ex_vec_q     <= 6'h0;
      ws_ertn_q       <= 1'b0;
      ws_csr_we_q     <= 1'b0;
      ws_csr_num_q    <= 14'h0;
      ws_csr_wmask_q  <= 32'h0;
      ws_csr_wvalue_q <= 32'h0;
      ws_rf_we_q      <= 1'b0;
      ws_rf_waddr_q   <= 5'h0;
      ws_rf_wdata_q   <= 32'h0;
    end else begin
      // allowin is low on the flush edge, so this also drops ws_valid there
      ws_valid_q <= ws_valid_d;
      if (ws_valid_d) begin
        ws_pc_q         <= bus.ms_pc;
        ws_vaddr_q      <= bus.ms_vaddr;
        ws_ex_vec_q     <= bus.ms_ex_vec;
        ws_ertn_q       <= bus.ms_ertn;
        ws_csr_we_q     <= bus.ms_csr_we;
        ws_csr_num_q    <= bus.ms_csr_num;
        ws_csr_wmask_q  <= bus.ms_csr_wmask;
        ws_csr_wvalue_q <= bus.ms_csr_wvalue;
        ws_rf_we_q      <= bus.ms_rf_we;
        ws_rf_waddr_q   <= bus.ms_rf_waddr;
        ws_rf_wdata_q   <= bus.ms_rf_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (flush_now) begin
            state_q          <= S_REDIR;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= ws_ex ? bus.ex_entry : bus.ertn_entry;
          end
        end
        S_REDIR: begin
          if (bus.redirect_ready) begin
            state_q          <= S_RUN;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= S_RUN;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ws_allowin     = allowin;
  assign bus.wb_ex          = ws_ex;
  assign bus.ertn_flush     = ertn_now;
  assign bus.wb_ecode       = ecode;
  assign bus.wb_esubcode    = esubcode;
  assign bus.wb_csr_pc      = ws_pc_q;
  assign bus.debug_wb_pc    = ws_pc_q;
  assign bus.wb_vaddr       = ws_vaddr_q;
  assign bus.csr_we         = ws_valid_q && in_run && ws_csr_we_q && !ws_ex;
  assign bus.csr_num        = ws_csr_num_q;
  assign bus.csr_wmask      = ws_csr_wmask_q;
  assign bus.csr_wvalue     = ws_csr_wvalue_q;
  assign bus.rf_we          = ws_valid_q && in_run && ws_rf_we_q && !ws_ex
                              && (ws_rf_waddr_q != 5'd0);
  assign bus.rf_waddr       = ws_rf_waddr_q;
  assign bus.rf_wdata       = ws_rf_wdata_q;
  assign bus.flush_out      = flush_now || (state_q == S_REDIR);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_commit_q;
  logic [31:0] perf_ex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_commit_q <= 32'h0;
      perf_ex_q     <= 32'h0;
    end else begin
      if (ws_valid_q && !ws_ex && in_run) perf_commit_q <= perf_commit_q + 32'd1;
      if (ws_ex)                          perf_ex_q     <= perf_ex_q + 32'd1;
    end
  end

  assign perf_commit_cnt = perf_commit_q;
  assign perf_ex_cnt     = perf_ex_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_ctrl : directed self-checking bench for wb_commit_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_commit_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_commit_ctrl_if bus ();

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt;
  logic [31:0] perf_ex_cnt;
`endif

  wb_commit_ctrl u_dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_commit_cnt (perf_commit_cnt),
    .perf_ex_cnt     (perf_ex_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ms();
    bus.ms_to_ws_valid = 1'b0;
    bus.ms_pc          = 32'h0;
    bus.ms_vaddr       = 32'h0;
    bus.ms_ex_vec      = 6'h0;
    bus.ms_ertn        = 1'b0;
    bus.ms_csr_we      = 1'b0;
    bus.ms_csr_num     = 14'h0;
    bus.ms_csr_wmask   = 32'h0;
    bus.ms_csr_wvalue  = 32'h0;
    bus.ms_rf_we       = 1'b0;
    bus.ms_rf_waddr    = 5'h0;
    bus.ms_rf_wdata    = 32'h0;
  endtask

  task automatic load_and_drop();
    bus.ms_to_ws_valid = 1'b1;
    tick();
    clear_ms();
  endtask

  task automatic drain_redirect();
    tick();
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_ms();
    bus.has_int        = 1'b0;
    bus.ex_entry       = 32'h1c008000;
    bus.ertn_entry     = 32'h1c000100;
    bus.redirect_ready = 1'b0;
    reset              = 1'b1;

    tick();
    tick();
    chk("rst_allowin",   32'(bus.ws_allowin),     32'h1);
    chk("rst_rf_we",     32'(bus.rf_we),          32'h0);
    chk("rst_wb_ex",     32'(bus.wb_ex),          32'h0);
    chk("rst_redir_v",   32'(bus.redirect_valid), 32'h0);
    chk("rst_redir_pc",  bus.redirect_pc,         32'h0);
    chk("rst_flush",     32'(bus.flush_out),      32'h0);
    chk("rst_dbg_pc",    bus.debug_wb_pc,         32'h0);
    reset = 1'b0;
    tick();

    // Plain ADD commit
    bus.ms_pc = 32'h1c000000; bus.ms_rf_we = 1'b1;
    bus.ms_rf_waddr = 5'd5;   bus.ms_rf_wdata = 32'h1234;
    load_and_drop();
    chk("add_rf_we",     32'(bus.rf_we),       32'h1);
    chk("add_waddr",     32'(bus.rf_waddr),    32'h5);
    chk("add_wdata",     bus.rf_wdata,         32'h1234);
    chk("add_wb_ex",     32'(bus.wb_ex),       32'h0);
    chk("add_flush",     32'(bus.flush_out),   32'h0);
    chk("add_dbg_pc",    bus.debug_wb_pc,      32'h1c000000);
    tick();
    chk("add_rf_we_off", 32'(bus.rf_we),       32'h0);

    // SYS + ALE: SYS wins, writes suppressed
    bus.ms_pc = 32'h1c000010; bus.ms_ex_vec = 6'b100100;
    bus.ms_rf_we = 1'b1; bus.ms_rf_waddr = 5'd3; bus.ms_csr_we = 1'b1;
    load_and_drop();
    chk("sys_rf_we",     32'(bus.rf_we),       32'h0);
    chk("sys_csr_we",    32'(bus.csr_we),      32'h0);
    chk("sys_wb_ex",     32'(bus.wb_ex),       32'h1);
    chk("sys_ecode",     32'(bus.wb_ecode),    32'hB);
    chk("sys_esub",      32'(bus.wb_esubcode), 32'h0);
    chk("sys_flush",     32'(bus.flush_out),   32'h1);
    chk("sys_allowin",   32'(bus.ws_allowin),  32'h0);
    chk("sys_csr_pc",    bus.wb_csr_pc,        32'h1c000010);
    tick();
    chk("sys_redir_v",   32'(bus.redirect_valid), 32'h1);
    chk("sys_redir_pc",  bus.redirect_pc,         32'h1c008000);
    chk("sys_redir_fl",  32'(bus.flush_out),      32'h1);
    chk("sys_redir_ex",  32'(bus.wb_ex),          32'h0);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    chk("sys_back_v",    32'(bus.redirect_valid), 32'h0);
    chk("sys_back_alw",  32'(bus.ws_allowin),     32'h1);

    // Interrupt beats ADEM
    bus.has_int = 1'b1; bus.ms_ex_vec = 6'b010000; bus.ms_pc = 32'h1c000020;
    load_and_drop();
    chk("int_wb_ex",     32'(bus.wb_ex),       32'h1);
    chk("int_ecode",     32'(bus.wb_ecode),    32'h0);
    chk("int_esub",      32'(bus.wb_esubcode), 32'h0);
    bus.has_int = 1'b0;
    drain_redirect();

    // ADEM alone
    bus.ms_ex_vec = 6'b010000; bus.ms_vaddr = 32'h3;
    load_and_drop();
    chk("adem_ecode",    32'(bus.wb_ecode),    32'h8);
    chk("adem_esub",     32'(bus.wb_esubcode), 32'h1);
    chk("adem_vaddr",    bus.wb_vaddr,         32'h3);
    drain_redirect();

    // INE beats BRK; ADEF beats INE
    bus.ms_ex_vec = 6'b001010;
    load_and_drop();
    chk("ine_ecode",     32'(bus.wb_ecode),    32'hD);
    drain_redirect();
    bus.ms_ex_vec = 6'b000011;
    load_and_drop();
    chk("adef_ecode",    32'(bus.wb_ecode),    32'h8);
    chk("adef_esub",     32'(bus.wb_esubcode), 32'h0);
    drain_redirect();

    // ERTN with redirect_ready low for 3 REDIR cycles
    bus.ms_ertn = 1'b1; bus.ms_pc = 32'h1c000030;
    load_and_drop();
    chk("ertn_flush",    32'(bus.ertn_flush),  32'h1);
    chk("ertn_wb_ex",    32'(bus.wb_ex),       32'h0);
    chk("ertn_allowin",  32'(bus.ws_allowin),  32'h0);
    chk("ertn_flushout", 32'(bus.flush_out),   32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ertn_pulse",  32'(bus.ertn_flush),     32'h0);
      chk("ertn_redir_v", 32'(bus.redirect_valid), 32'h1);
      chk("ertn_redir_pc", bus.redirect_pc,        32'h1c000100);
      chk("ertn_hold_alw", 32'(bus.ws_allowin),    32'h0);
      if (i == 3) bus.redirect_ready = 1'b1;
      tick();
    end
    bus.redirect_ready = 1'b0;
    chk("ertn_back_v",   32'(bus.redirect_valid), 32'h0);
    chk("ertn_back_alw", 32'(bus.ws_allowin),     32'h1);

    // CSR write, GPR write to r0 suppressed
    bus.ms_csr_we = 1'b1; bus.ms_csr_num = 14'h30;
    bus.ms_csr_wmask = 32'hFFFFFFFF; bus.ms_csr_wvalue = 32'hABCD;
    bus.ms_rf_we = 1'b1; bus.ms_rf_waddr = 5'd0; bus.ms_rf_wdata = 32'h55;
    load_and_drop();
    chk("csr_we",        32'(bus.csr_we),      32'h1);
    chk("csr_num",       32'(bus.csr_num),     32'h30);
    chk("csr_wmask",     bus.csr_wmask,        32'hFFFFFFFF);
    chk("csr_wvalue",    bus.csr_wvalue,       32'hABCD);
    chk("csr_r0_rf_we",  32'(bus.rf_we),       32'h0);
    chk("csr_flush",     32'(bus.flush_out),   32'h0);
    tick();
    chk("csr_we_off",    32'(bus.csr_we),      32'h0);
`ifdef WB_PERF_CNT_EN
    chk("perf_commit",   perf_commit_cnt,      32'd3);
    chk("perf_ex",       perf_ex_cnt,          32'd5);
`endif

    // Reset while in REDIR
    bus.ms_ex_vec = 6'b000100;
    load_and_drop();
    tick();
    chk("mid_redir_v",   32'(bus.redirect_valid), 32'h1);
    reset = 1'b1;
    tick();
    chk("rr_redir_v",    32'(bus.redirect_valid), 32'h0);
    chk("rr_flush",      32'(bus.flush_out),      32'h0);
    chk("rr_allowin",    32'(bus.ws_allowin),     32'h1);
    chk("rr_redir_pc",   bus.redirect_pc,         32'h0);
`ifdef WB_PERF_CNT_EN
    chk("rr_perf_commit", perf_commit_cnt,        32'd0);
    chk("rr_perf_ex",     perf_ex_cnt,            32'd0);
`endif
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
